stopwatch_lap: RTL
==================

# stopwatch_lap

Parametrised decimal stopwatch driving N_DIGITS seven-segment digits from three active-low push-button strobes. It provides start/pause/resume, clear, and a lap (split) hold that freezes the display while counting continues. A sticky overflow flag marks a wrap past the maximum count. It sits between the debounced button synchronisers and the board's FND pins, and supersedes the fixed three-digit, 20 Hz stopwatch.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 20: count rate; DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2.
- N_DIGITS, 3: number of BCD digits, 1..8; digit 0 is least significant.
- i_Clk  in  1  clock; all logic on rising edge.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_fStart  in  1  start/pause button, active-low, already synchronised and debounced.
- i_fStop  in  1  stop/clear button, active-low.
- i_fLap  in  1  lap button, active-low.
- o_Fnd  out  7*N_DIGITS  segments; digit k occupies bits [7k+6:7k]; uses the team's standard 7-seg digit encoding.
- o_Run  out  1  high in RUN or LAP.
- o_Lap  out  1  high while the display is frozen (LAP).
- o_Ovf  out  1  sticky overflow flag.

## Operation
- Press detection: each button has a previous-sample register, reset to 1. A press is a one-cycle pulse when the input is 0 and the previous sample is 1. A button held low through reset produces no press.
- Priority when presses coincide: stop > start > lap.
- States: IDLE, RUN, PAUSE, LAP.
  - IDLE: prescaler, digits, snapshot and o_Ovf are held at 0. Start → RUN. Lap is ignored.
  - RUN: counting. Stop → IDLE. Start → PAUSE. Lap → LAP, capturing the digits into the snapshot.
  - LAP: counting continues; the display shows the snapshot. Stop → IDLE. Start → PAUSE, and the display returns to live. Lap → RUN, with a live display.
  - PAUSE: prescaler and digits hold; live display. Stop → IDLE. Start → RUN. Lap is ignored.
- Prescaler counts 0..DIV-1 in RUN and LAP. On the cycle it equals DIV-1 it returns to 0 and issues a tick.
- On a tick, digit 0 increments. Digit k increments when digit k-1 is 9 and a tick occurs. A digit at 9 that increments becomes 0.
- All digits at 9 on a tick: every digit becomes 0, o_Ovf sets to 1 and stays set until IDLE. Counting continues.
- The displayed value is the snapshot in LAP and the live digits otherwise. o_Fnd is a combinational decode of the displayed value.

## Timing
- Reset values: state IDLE, all digits 0, o_Fnd shows "0" on every digit, o_Run=0, o_Lap=0, o_Ovf=0, button samples 1.
- A press detected at edge t changes state, o_Run and o_Lap at edge t+1. The snapshot is captured at that same edge.
- RUN is entered with the prescaler at 0. The first tick occurs DIV cycles after entry.
- A tick and a lap press in the same cycle: the snapshot takes the pre-increment value.
- A tick and a start press in the same cycle (RUN→PAUSE): the increment is applied, then the count holds.
- Stop in the same cycle as a tick: the next state is IDLE with all values cleared; the tick is discarded.
- Mid-operation reset returns all registers to reset values immediately (asynchronous).

## Configuration
- STOPWATCH_LAP_EN defined: LAP state, snapshot register and o_Lap are present as specified above.
- STOPWATCH_LAP_EN undefined:
  - The LAP state and snapshot are removed, and i_fLap is ignored.
  - o_Lap is tied to 0 and the display is always live.
  - All other behaviour is unchanged.

## Structure
- Package stopwatch_pkg:
  - state enum (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11)
  - 4-bit BCD digit type
  - function returning prescaler width, $clog2(DIV)
- Sub-module fnd_digit: 4-bit BCD in, 7-bit segments out. It is instantiated N_DIGITS times in a generate loop.
- Digit chain, prescaler and FSM reside in stopwatch_lap.

## Test plan
- Test configuration: CLK_HZ=20, TICK_HZ=2 (DIV=10), N_DIGITS=2, unless noted.
- Reset with all buttons high → o_Fnd shows "00", o_Run=0, o_Ovf=0. Hold i_fStart low through reset release → stays IDLE.
- Start press, run 95 cycles → display "09". At 100 cycles → "10".
- Start press in RUN → PAUSE; value holds for 50 cycles. Start press again → RUN; counting resumes from the held prescaler value.
- Lap press at count 05 → o_Lap=1, display frozen at "05" while the internal count reaches 12. Lap press → display "12" live.
- Run 1000 cycles from start → count wraps 99→00 and o_Ovf=1. Stop press → display "00", o_Ovf=0, IDLE.
- Simultaneous stop and start presses in RUN → IDLE. Build without STOPWATCH_LAP_EN, lap press in RUN → no change, o_Lap=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and helpers for the stopwatch_lap block.
//   state_e     : controller states (IDLE/RUN/PAUSE/LAP).
//   bcd_t       : one decimal digit, 4-bit BCD.
//   BCD_NINE    : largest digit value, the carry point of the digit chain.
//   presc_width : bit width of a prescaler that counts 0..div-1.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_NINE = 4'd9;

   function automatic int presc_width(input int div);
      return $clog2(div);
   endfunction

endpackage

// File: rtl/fnd_digit.sv
// -----------------------------------------------------------------------------
// fnd_digit
// Decodes one BCD digit to seven-segment drive, active-high, bit order
// {g,f,e,d,c,b,a} (bit 0 = segment a). Codes above 9 blank the digit.
//   bcd_i : BCD digit in.
//   seg_o : segment pattern out.
// -----------------------------------------------------------------------------
module fnd_digit
   import stopwatch_pkg::*;
(
   input  bcd_t       bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = 7'h3F;
         4'd1:    seg_o = 7'h06;
         4'd2:    seg_o = 7'h5B;
         4'd3:    seg_o = 7'h4F;
         4'd4:    seg_o = 7'h66;
         4'd5:    seg_o = 7'h6D;
         4'd6:    seg_o = 7'h7D;
         4'd7:    seg_o = 7'h07;
         4'd8:    seg_o = 7'h7F;
         4'd9:    seg_o = 7'h6F;
         default: seg_o = 7'h00;
      endcase
   end

endmodule

// File: rtl/stopwatch_lap.sv
// -----------------------------------------------------------------------------
// stopwatch_lap
// Decimal stopwatch with start/pause, clear, lap (split) hold and a sticky
// overflow flag, driving N_DIGITS seven-segment digits.
// Build option: define STOPWATCH_LAP_EN to include the LAP state, snapshot
// register and o_Lap; without it i_fLap is ignored and o_Lap is 0.
//   i_Clk    : clock, rising edge.
//   i_Rst    : asynchronous reset, active-low.
//   i_fStart : start/pause button, active-low, debounced.
//   i_fStop  : stop/clear button, active-low, debounced.
//   i_fLap   : lap button, active-low, debounced.
//   o_Fnd    : segments, digit k at [7k+6:7k], digit 0 least significant.
//   o_Run    : high in RUN or LAP.
//   o_Lap    : high while the display is frozen on the snapshot.
//   o_Ovf    : set when the count wraps past all nines, cleared in IDLE.
// -----------------------------------------------------------------------------
module stopwatch_lap
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 20,
   parameter int N_DIGITS = 3
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_fStart,
   input  logic                  i_fStop,
   input  logic                  i_fLap,
   output logic [7*N_DIGITS-1:0] o_Fnd,
   output logic                  o_Run,
   output logic                  o_Lap,
   output logic                  o_Ovf
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = presc_width(DIV);

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   bcd_t            digits_q [N_DIGITS];
   bcd_t            digits_d [N_DIGITS];
   logic            ovf_q, ovf_d;
   logic            carry;

   // Button edge detection. armed_q stays low for the first cycle after
   // reset so a button already held low at release is not seen as a press.
   logic            armed_q;
   logic            start_prev_q, stop_prev_q;
   logic            start_press_q, stop_press_q;
   logic            lap_press;

`ifdef STOPWATCH_LAP_EN
   logic            lap_prev_q, lap_press_q;
   bcd_t            snap_q [N_DIGITS];
   bcd_t            snap_d [N_DIGITS];

   assign lap_press = lap_press_q;
`else
   logic            unused_lap;

   assign unused_lap = i_fLap;
   assign lap_press  = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q       <= ST_IDLE;
         presc_q       <= '0;
         ovf_q         <= 1'b0;
         armed_q       <= 1'b0;
         start_prev_q  <= 1'b1;
         stop_prev_q   <= 1'b1;
         start_press_q <= 1'b0;
         stop_press_q  <= 1'b0;
         for (int k = 0; k < N_DIGITS; k++) digits_q[k] <= '0;
`ifdef STOPWATCH_LAP_EN
         lap_prev_q    <= 1'b1;
         lap_press_q   <= 1'b0;
         for (int k = 0; k < N_DIGITS; k++) snap_q[k] <= '0;
`endif
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         ovf_q         <= ovf_d;
         armed_q       <= 1'b1;
         start_prev_q  <= i_fStart;
         stop_prev_q   <= i_fStop;
         start_press_q <= armed_q & start_prev_q & ~i_fStart;
         stop_press_q  <= armed_q & stop_prev_q & ~i_fStop;
         digits_q      <= digits_d;
`ifdef STOPWATCH_LAP_EN
         lap_prev_q    <= i_fLap;
         lap_press_q   <= armed_q & lap_prev_q & ~i_fLap;
         snap_q        <= snap_d;
`endif
      end
   end

   // NOTE: every variable gets its hold value first, so no branch can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      ovf_d    = ovf_q;
      carry    = 1'b0;
`ifdef STOPWATCH_LAP_EN
      snap_d   = snap_q;
`endif

      // Priority on coincident presses: stop > start > lap.
      case (state_q)
         ST_IDLE:  if (start_press_q) state_d = ST_RUN;
         ST_RUN: begin
            if (stop_press_q)       state_d = ST_IDLE;
            else if (start_press_q) state_d = ST_PAUSE;
            else if (lap_press)     state_d = ST_LAP;
         end
         ST_PAUSE: begin
            if (stop_press_q)       state_d = ST_IDLE;
            else if (start_press_q) state_d = ST_RUN;
         end
`ifdef STOPWATCH_LAP_EN
         ST_LAP: begin
            if (stop_press_q)       state_d = ST_IDLE;
            else if (start_press_q) state_d = ST_PAUSE;
            else if (lap_press)     state_d = ST_RUN;
         end
`endif
         default:                   state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) begin
         // Clearing wins over a tick landing on the same edge.
         presc_d = '0;
         ovf_d   = 1'b0;
         for (int k = 0; k < N_DIGITS; k++) digits_d[k] = '0;
`ifdef STOPWATCH_LAP_EN
         for (int k = 0; k < N_DIGITS; k++) snap_d[k] = '0;
`endif
      end else if (state_q == ST_RUN || state_q == ST_LAP) begin
         if (presc_q == PW'(DIV - 1)) begin
            presc_d = '0;
            carry   = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
         // Ripple the tick up the digit chain; a carry out of the top
         // digit means every digit was 9.
         for (int k = 0; k < N_DIGITS; k++) begin
            if (carry) begin
               if (digits_q[k] == BCD_NINE) begin
                  digits_d[k] = '0;
               end else begin
                  digits_d[k] = digits_q[k] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
         if (carry) ovf_d = 1'b1;
`ifdef STOPWATCH_LAP_EN
         // Snapshot takes the pre-increment count.
         if (state_q == ST_RUN && state_d == ST_LAP) snap_d = digits_q;
`endif
      end
   end

   assign o_Run = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign o_Ovf = ovf_q;
`ifdef STOPWATCH_LAP_EN
   assign o_Lap = (state_q == ST_LAP);
`else
   assign o_Lap = 1'b0;
`endif

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_fnd
      bcd_t disp;
`ifdef STOPWATCH_LAP_EN
      assign disp = (state_q == ST_LAP) ? snap_q[g] : digits_q[g];
`else
      assign disp = digits_q[g];
`endif
      fnd_digit u_fnd_digit (
         .bcd_i (disp),
         .seg_o (o_Fnd[7*g +: 7])
      );
   end

endmodule
